// File: rtl/noc_input_port.sv
// Router input port: DEPTH-entry flit FIFO with XY route labelling of the head flit.
// Optional saturating dropped-write counter enabled by defining NOC_INPUT_DROP_CNT_EN.
module noc_input_port #(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 3,
    parameter int DATASIZE = 40,
    parameter int LOCAL_X  = 0,
    parameter int LOCAL_Y  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                data_valid,
    input  logic [DATASIZE-1:0] data_in,
    output logic                full,
    input  logic                ready,
    output logic [3:0]          label,
    output logic [DATASIZE-1:0] data_out,
    output logic [WIDTH:0]      count,
    output logic [7:0]          drop_cnt
);

    localparam logic [WIDTH:0] FULL_COUNT  = (WIDTH+1)'(DEPTH);
    localparam logic [WIDTH:0] EMPTY_COUNT = (WIDTH+1)'(0);
    localparam logic [1:0]     LX          = 2'(LOCAL_X);
    localparam logic [1:0]     LY          = 2'(LOCAL_Y);

    logic [DATASIZE-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0]    wr_ptr_r;
    logic [WIDTH-1:0]    rd_ptr_r;
    logic [WIDTH:0]      count_r;
    logic [WIDTH:0]      count_next_s;
    logic                full_r;
    logic                push_s;
    logic                pop_s;
    logic [DATASIZE-1:0] head_s;
    logic [3:0]          label_s;

    // Dimension-ordered route: resolve X first, then Y; equal in both means local.
    function automatic logic [2:0] xy_route(input logic [3:0] dst);
        logic [1:0] dx;
        logic [1:0] dy;
        logic [2:0] dir;
        dx = dst[3:2];
        dy = dst[1:0];
        if (dx > LX) begin
            dir = 3'd2;
        end else if (dx < LX) begin
            dir = 3'd4;
        end else if (dy > LY) begin
            dir = 3'd1;
        end else if (dy < LY) begin
            dir = 3'd3;
        end else begin
            dir = 3'd0;
        end
        return dir;
    endfunction

    // Full is judged on the registered state only, so ready never reaches full combinationally.
    assign push_s = data_valid && !full_r;
    assign pop_s  = ready && (count_r != EMPTY_COUNT);

    // Next occupancy from the push/pop pair
    always_comb begin
        count_next_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + (WIDTH+1)'(1);
            2'b01:   count_next_s = count_r - (WIDTH+1)'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Pointers, occupancy and full flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= WIDTH'(0);
            rd_ptr_r <= WIDTH'(0);
            count_r  <= EMPTY_COUNT;
            full_r   <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + WIDTH'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + WIDTH'(1);
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == FULL_COUNT);
        end
    end

    // Flit storage; contents are meaningless once count returns to zero, so no reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= data_in;
        end
    end

    assign head_s = mem_r[rd_ptr_r];

    // Route request for the head flit, forced to zero while empty
    always_comb begin
        label_s = 4'b0000;
        if (count_r != EMPTY_COUNT) begin
            label_s = {1'b1, xy_route(head_s[35:32])};
        end else begin
            label_s = 4'b0000;
        end
    end

    assign data_out = head_s;
    assign label    = label_s;
    assign count    = count_r;
    assign full     = full_r;

`ifdef NOC_INPUT_DROP_CNT_EN
    logic [7:0] drop_cnt_r;

    // Saturating count of writes offered while full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_r <= 8'd0;
        end else if (data_valid && full_r && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign drop_cnt = drop_cnt_r;
`else
    assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_noc_input_port.sv
// Directed self-checking bench for noc_input_port at mesh position (1,1).
module tb_noc_input_port;

    logic        clk;
    logic        rst;
    logic        data_valid;
    logic [39:0] data_in;
    logic        full;
    logic        ready;
    logic [3:0]  label;
    logic [39:0] data_out;
    logic [3:0]  count;
    logic [7:0]  drop_cnt;

    int checks;
    int errors;

    noc_input_port #(
        .DEPTH(8), .WIDTH(3), .DATASIZE(40), .LOCAL_X(1), .LOCAL_Y(1)
    ) dut (
        .clk(clk), .rst(rst), .data_valid(data_valid), .data_in(data_in),
        .full(full), .ready(ready), .label(label), .data_out(data_out),
        .count(count), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [39:0] make_flit(input logic [3:0] dst, input logic [21:0] pl);
        return {4'hA, dst, 8'h5C, pl, 2'b10};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [3:0]  dsts   [5];
    logic [3:0]  labels [5];
    logic [63:0] exp_drop;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; data_valid = 1'b0; ready = 1'b0; data_in = 40'd0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_full", 64'(full), 64'd0);
        chk("reset_label", 64'(label), 64'd0);
        chk("reset_drop", 64'(drop_cnt), 64'd0);

        // fill to 5, then asynchronous reset away from any clock edge
        data_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_in = make_flit(4'b0101, 22'(i + 100));
            tick();
        end
        data_valid = 1'b0;
        chk("pre_rst_count", 64'(count), 64'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_count", 64'(count), 64'd0);
        chk("async_rst_label", 64'(label), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // XY routing, one flit at a time
        dsts   = '{4'b1001, 4'b0001, 4'b0110, 4'b0100, 4'b0101};
        labels = '{4'b1010, 4'b1100, 4'b1001, 4'b1011, 4'b1000};
        for (int i = 0; i < 5; i++) begin
            data_valid = 1'b1;
            data_in = make_flit(dsts[i], 22'(i + 1));
            tick();
            data_valid = 1'b0;
            chk("route_label", 64'(label), 64'(labels[i]));
            chk("route_data", 64'(data_out), 64'(make_flit(dsts[i], 22'(i + 1))));
            ready = 1'b1;
            tick();
            ready = 1'b0;
            chk("route_pop_label", 64'(label), 64'd0);
        end

        // fill completely, offer a ninth flit, drain in order
        data_valid = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            data_in = make_flit(4'b0101, 22'(i));
            tick();
        end
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_count", 64'(count), 64'd8);
        data_in = make_flit(4'b0101, 22'd9);
        tick();
        data_valid = 1'b0;
        chk("drop_count", 64'(count), 64'd8);
`ifdef NOC_INPUT_DROP_CNT_EN
        exp_drop = 64'd1;
`else
        exp_drop = 64'd0;
`endif
        chk("drop_cnt_1", 64'(drop_cnt), exp_drop);
        ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_order", 64'(data_out), 64'(make_flit(4'b0101, 22'(i))));
            tick();
        end
        ready = 1'b0;
        chk("drain_label", 64'(label), 64'd0);
        chk("drain_count", 64'(count), 64'd0);

        // steady push+pop at occupancy 4 across the pointer wrap
        data_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            data_in = make_flit(4'b1001, 22'(16 + i));
            tick();
        end
        ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            data_in = make_flit(4'b1001, 22'(20 + k));
            chk("wrap_head", 64'(data_out), 64'(make_flit(4'b1001, 22'(16 + k))));
            tick();
            chk("wrap_count", 64'(count), 64'd4);
        end
        data_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("wrap_tail", 64'(data_out), 64'(make_flit(4'b1001, 22'(26 + k))));
            tick();
        end
        ready = 1'b0;
        chk("wrap_empty", 64'(count), 64'd0);

        // push and pop together while full: pop wins this cycle, push lands next
        data_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_in = make_flit(4'b0001, 22'(40 + i));
            tick();
        end
        chk("full_again", 64'(full), 64'd1);
        data_in = make_flit(4'b0001, 22'd48);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("full_pop_count", 64'(count), 64'd7);
        chk("full_pop_flag", 64'(full), 64'd0);
        chk("full_pop_head", 64'(data_out), 64'(make_flit(4'b0001, 22'd41)));
        tick();
        data_valid = 1'b0;
        chk("full_repush_count", 64'(count), 64'd8);
        chk("full_repush_flag", 64'(full), 64'd1);
`ifdef NOC_INPUT_DROP_CNT_EN
        exp_drop = 64'd2;
`else
        exp_drop = 64'd0;
`endif
        chk("drop_cnt_2", 64'(drop_cnt), exp_drop);
        ready = 1'b1;
        for (int i = 41; i <= 48; i++) begin
            chk("full_drain", 64'(data_out), 64'(make_flit(4'b0001, 22'(i))));
            tick();
        end
        chk("full_drain_count", 64'(count), 64'd0);

        // ready on an empty FIFO must not move anything
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("empty_ready_count", 64'(count), 64'd0);
            chk("empty_ready_label", 64'(label), 64'd0);
        end
        ready = 1'b0;
        data_valid = 1'b1;
        data_in = make_flit(4'b0110, 22'd60);
        tick();
        data_valid = 1'b0;
        chk("post_empty_data", 64'(data_out), 64'(make_flit(4'b0110, 22'd60)));
        chk("post_empty_label", 64'(label), 64'(4'b1001));
        chk("post_empty_count", 64'(count), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/noc_input_port.md
Name: noc_input_port

Overview:
- Receive side of a router link: one instance per router input (L, N, E, S, W).
- Accepts flits from the upstream sender's data_valid/data_out pair and buffers them in a DEPTH-entry FIFO.
- Back-pressures the sender through full.
- Presents the head flit plus an XY-routed label to the switch allocator and dequeues when the allocator asserts ready.

Parameters:
- DEPTH, 8: FIFO entries; must equal 2**WIDTH.
- WIDTH, 3: pointer width.
- DATASIZE, 40: flit width.
- LOCAL_X, 0: this router's mesh X coordinate (0..3).
- LOCAL_Y, 0: this router's mesh Y coordinate (0..3).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- data_valid  input  1  upstream flit valid.
- data_in  input  DATASIZE  upstream flit.
- full  output  1  FIFO full; upstream must not send while high.
- ready  input  1  allocator grant: pop the head flit this cycle.
- label  output  4  route request for the head flit.
- data_out  output  DATASIZE  head flit.
- count  output  WIDTH+1  current occupancy.
- drop_cnt  output  8  dropped-write counter (see Optional Feature).

Behaviour:
- Flit fields:
  - src [39:36]
  - dst [35:32], with dst_x = [35:34] and dst_y = [33:32]
  - timestamp [31:24]
  - payload [23:2]
  - type [1:0]
- Reset (async, rst=1): rd_ptr=0, wr_ptr=0, count=0, full=0, label=4'b0000, drop_cnt=0. data_out is don't-care while empty. Reset asserted mid-operation discards all stored flits immediately.
- Push: data_valid && !full. The flit is written at wr_ptr; wr_ptr increments mod DEPTH.
- Write while full: the flit is ignored and the FIFO is unchanged.
- Pop: ready && count!=0. rd_ptr increments mod DEPTH.
- ready while empty: ignored; no pointer or count change.
- Simultaneous push and pop: both take effect and count is unchanged.
  - Full is judged on the registered count. A push in the same cycle as a pop from a full FIFO is rejected.
- count update: +1 on push only, -1 on pop only, unchanged otherwise. Range 0..DEPTH.
- full is a registered-equivalent decode of count==DEPTH. There is no combinational path from ready to full.
- Pointer wrap: pointers are WIDTH bits and wrap naturally from DEPTH-1 to 0. Empty/full come from count only, never from pointer compare.
- Latency: a flit pushed in cycle N appears on data_out/label in cycle N+1 if the FIFO was empty; otherwise it appears when it reaches the head.
- data_out = mem[rd_ptr], combinational read of the storage array.
- label[3] = (count!=0). label[2:0] = XY route of the head flit:
  - dst_x > LOCAL_X -> 3'd2 (E)
  - dst_x < LOCAL_X -> 3'd4 (W)
  - dst_x == LOCAL_X and dst_y > LOCAL_Y -> 3'd1 (N)
  - dst_x == LOCAL_X and dst_y < LOCAL_Y -> 3'd3 (S)
  - both equal -> 3'd0 (L)
- label = 4'b0000 whenever the FIFO is empty.
- Flit contents are not modified; the router is transparent to the timestamp and type fields.

Optional Feature:
- Macro NOC_INPUT_DROP_CNT_EN.
- Defined:
  - drop_cnt is an 8-bit register that increments each cycle data_valid && full.
  - It saturates at 255 and clears only on rst.
- Undefined: drop_cnt is tied to 8'd0 and no counter logic is built. FIFO behaviour is identical in both builds.

Test Plan:
- Reset, then idle:
  - Expect count=0, full=0, label=0000.
  - Assert rst for 1 cycle while count=5: count=0 and label=0000 immediately, asynchronously.
- LOCAL_X=1, LOCAL_Y=1; push flits with dst=4'b1001, 0001, 0110, 0100, 0101 one at a time, popping each before the next:
  - Expect label = 1010 (E), 1100 (W), 1001 (N), 1011 (S), 1000 (L) respectively.
  - data_out must equal the pushed flit in each case.
- Push 8 flits back-to-back (payloads 1..8):
  - full=1 after the 8th push.
  - A 9th data_valid is ignored; with NOC_INPUT_DROP_CNT_EN, drop_cnt=1.
  - Pop 8: data_out order is 1..8, then label=0000 and count=0.
- count=4, data_valid and ready together for 10 cycles:
  - count stays 4 and output order is preserved across the pointer wrap.
- count=8 (full), data_valid and ready in the same cycle:
  - Pop occurs, push is rejected, count=7.
  - Next cycle the push is accepted and count=8.
- ready asserted while empty for 3 cycles:
  - No change; count=0, pointers unchanged.
  - A subsequent single push appears at data_out the next cycle.
